// File: rtl/branch_history_table_if.sv
// Prediction-request and training bus of the bimodal branch history table.
// master = fetch/resolve side, slave = the table itself.
interface branch_history_table_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
);

  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_resp;
  logic [1:0]       rd_count;
  logic             rd_taken;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output rd_valid, rd_idx, upd_valid, upd_idx, upd_taken,
    input  rd_resp, rd_count, rd_taken, mispred_cnt
  );

  modport slave (
    input  rd_valid, rd_idx, upd_valid, upd_idx, upd_taken,
    output rd_resp, rd_count, rd_taken, mispred_cnt
  );

endinterface

// File: rtl/branch_history_table.sv
// Bimodal predictor: 2**IDX_W two-bit saturating counters, one-cycle read port
// with same-cycle update forwarding, plus a saturating mispredict counter.
module branch_history_table #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  branch_history_table_if.slave   bus
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [1:0]       cnt_tbl_q [Depth];
  logic [1:0]       cnt_tbl_d [Depth];
  logic [1:0]       upd_cur;
  logic [1:0]       upd_next;
  logic             mispredict;
  logic             rd_fwd;

  logic             rd_resp_q, rd_resp_d;
  logic [1:0]       rd_count_q, rd_count_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;

  // Training: saturating step of the addressed entry
  always_comb begin
    upd_cur  = cnt_tbl_q[bus.upd_idx];
    upd_next = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  always_comb begin
    cnt_tbl_d = cnt_tbl_q;
    if (bus.upd_valid) cnt_tbl_d[bus.upd_idx] = upd_next;
  end

  // Mispredict compares against the pre-update prediction bit
  assign mispredict = bus.upd_valid && (upd_cur[1] != bus.upd_taken);

  always_comb begin
    mispred_d = mispred_q;
    if (mispredict && !(&mispred_q)) mispred_d = mispred_q + CNT_W'(1);
  end

  // Read port; a same-index update this cycle is forwarded to the response
  assign rd_fwd = bus.upd_valid && (bus.upd_idx == bus.rd_idx);

  always_comb begin
    rd_resp_d  = bus.rd_valid;
    rd_count_d = rd_count_q;
    if (bus.rd_valid) rd_count_d = rd_fwd ? upd_next : cnt_tbl_q[bus.rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_tbl_q  <= '{default: 2'b00};
      rd_resp_q  <= 1'b0;
      rd_count_q <= 2'b00;
      mispred_q  <= '0;
    end else begin
      cnt_tbl_q  <= cnt_tbl_d;
      rd_resp_q  <= rd_resp_d;
      rd_count_q <= rd_count_d;
      mispred_q  <= mispred_d;
    end
  end

  assign bus.rd_resp     = rd_resp_q;
  assign bus.rd_count    = rd_count_q;
  assign bus.rd_taken    = rd_count_q[1];
  assign bus.mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed vector table, async-reset and
// counter-saturation sequences, then random traffic against a counter model.
module tb_branch_history_table;

  logic clk;
  logic rst_n;

  branch_history_table_if #(.IDX_W(4), .CNT_W(16)) bus ();
  branch_history_table_if #(.IDX_W(4), .CNT_W(2))  bus2 ();

  branch_history_table #(.IDX_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_history_table #(.IDX_W(4), .CNT_W(2)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers per entry
  int m_tbl [16];
  int m_mis;
  int m_count;
  int m_resp;

  typedef struct {
    bit rv;
    int ri;
    bit uv;
    int ui;
    bit ut;
    int exp_cnt;
    int exp_mis;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(bit rv, int ri, bit uv, int ui, bit ut, int ec, int em);
    vec_t v;
    v.rv = rv; v.ri = ri; v.uv = uv; v.ui = ui; v.ut = ut;
    v.exp_cnt = ec; v.exp_mis = em;
    return v;
  endfunction

  function automatic int sat_step(int c, bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 0;
    m_mis   = 0;
    m_count = 0;
    m_resp  = 0;
  endtask

  // One clock of traffic on the main DUT, checked against the model
  task automatic step(input bit rv, input int ri, input bit uv, input int ui, input bit ut);
    bus.rd_valid  = rv;
    bus.rd_idx    = ri[3:0];
    bus.upd_valid = uv;
    bus.upd_idx   = ui[3:0];
    bus.upd_taken = ut;
    @(posedge clk);
    m_resp = rv;
    if (rv) m_count = (uv && ui == ri) ? sat_step(m_tbl[ui], ut) : m_tbl[ri];
    if (uv) begin
      if ((m_tbl[ui] >= 2) != ut) m_mis = (m_mis >= 65535) ? 65535 : m_mis + 1;
      m_tbl[ui] = sat_step(m_tbl[ui], ut);
    end
    #1;
    check("rd_resp", bus.rd_resp, m_resp);
    check("rd_count", bus.rd_count, m_count);
    check("rd_taken", bus.rd_taken, int'(m_count >= 2));
    check("mispred_cnt", bus.mispred_cnt, m_mis);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bit rv, uv, ut;
    int ri, ui;

    rst_n = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_idx = '0;
    bus.upd_valid = 1'b0; bus.upd_idx = '0; bus.upd_taken = 1'b0;
    bus2.rd_valid = 1'b0; bus2.rd_idx = '0;
    bus2.upd_valid = 1'b0; bus2.upd_idx = '0; bus2.upd_taken = 1'b0;
    model_reset();

    #11;
    check("reset_rd_resp", bus.rd_resp, 0);
    check("reset_rd_count", bus.rd_count, 0);
    check("reset_mispred", bus.mispred_cnt, 0);
    rst_n = 1'b1;

    // Every entry reads strong not-taken after reset
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i, 1'b0, 0, 1'b0);
      check("init_count", bus.rd_count, 0);
    end

    // Train idx 3 up then down (idx 4 read alongside), then forwarding on idx 5
    vecs[0]  = mk(0, 0, 1, 3, 1, 0, 1);
    vecs[1]  = mk(1, 3, 0, 0, 0, 1, 1);
    vecs[2]  = mk(0, 0, 1, 3, 1, 0, 2);
    vecs[3]  = mk(1, 3, 0, 0, 0, 2, 2);
    vecs[4]  = mk(0, 0, 1, 3, 1, 0, 2);
    vecs[5]  = mk(1, 3, 0, 0, 0, 3, 2);
    vecs[6]  = mk(0, 0, 1, 3, 1, 0, 2);
    vecs[7]  = mk(1, 3, 0, 0, 0, 3, 2);
    vecs[8]  = mk(1, 4, 1, 3, 0, 0, 3);
    vecs[9]  = mk(1, 3, 0, 0, 0, 2, 3);
    vecs[10] = mk(1, 4, 1, 3, 0, 0, 4);
    vecs[11] = mk(1, 3, 0, 0, 0, 1, 4);
    vecs[12] = mk(1, 4, 1, 3, 0, 0, 4);
    vecs[13] = mk(1, 3, 0, 0, 0, 0, 4);
    vecs[14] = mk(1, 4, 1, 3, 0, 0, 4);
    vecs[15] = mk(1, 3, 0, 0, 0, 0, 4);
    vecs[16] = mk(0, 0, 1, 5, 1, 0, 5);
    vecs[17] = mk(1, 5, 1, 5, 1, 2, 6);
    vecs[18] = mk(0, 0, 0, 5, 1, 0, 6);

    foreach (vecs[k]) begin
      step(vecs[k].rv, vecs[k].ri, vecs[k].uv, vecs[k].ui, vecs[k].ut);
      if (vecs[k].rv) begin
        check("vec_count", bus.rd_count, vecs[k].exp_cnt);
        check("vec_taken", bus.rd_taken, int'(vecs[k].exp_cnt >= 2));
      end
      check("vec_mispred", bus.mispred_cnt, vecs[k].exp_mis);
    end

    // Asynchronous reset between edges with a read in flight
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 3, 1'b1);
    step(1'b1, 3, 1'b0, 0, 1'b0);
    check("pre_reset_count", bus.rd_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rd_resp", bus.rd_resp, 0);
    check("async_rd_count", bus.rd_count, 0);
    check("async_rd_taken", bus.rd_taken, 0);
    check("async_mispred", bus.mispred_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3, 1'b0, 0, 1'b0);
    check("post_reset_idx3", bus.rd_count, 0);

    // Narrow mispredict counter saturates at all-ones
    bus.rd_valid = 1'b0;
    bus.upd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus2.upd_valid = 1'b1;
      bus2.upd_idx   = 4'(i);
      bus2.upd_taken = 1'b1;
      @(posedge clk);
      #1;
      check("mispred_sat", bus2.mispred_cnt, (i + 1 > 3) ? 3 : i + 1);
    end
    bus2.upd_valid = 1'b0;
    step(1'b0, 0, 1'b0, 0, 1'b0);

    // Random traffic, biased toward a few indices so read/update collide
    for (int n = 0; n < 400; n++) begin
      rv = 1'($urandom);
      uv = 1'($urandom);
      ut = 1'($urandom);
      ri = ($urandom % 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      ui = ($urandom % 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      step(rv, ri, uv, ui, ut);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
